// File: rtl/add_stg_drain.sv
// Drains adder-stage words into an in-order DEPTH-entry FIFO; head visible one cycle after arrival (no bypass).
// add_en is credit-gated so FIFO plus in-flight words never exceed DEPTH; out_ready=0 simply holds the head.
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 16
`endif
`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 25
`endif

module add_stg_drain #(
  parameter int DATA_WIDTH   = `DATA_WIDTH_ADD_STG,
  parameter int BITS_ROW_IDX = `BITS_ROW_IDX,
  parameter int DEPTH        = 8,
  parameter int ADD_LAT      = 1
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       start,
  input  logic                       data_ended,
  input  logic [DATA_WIDTH-1:0]      data_out_add_stg,
  output logic                       add_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITS_ROW_IDX-1:0]    out_row_idx,
  output logic [`DATA_PRECISION-1:0] out_value,
  output logic [15:0]                out_count,
  output logic                       order_err,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(ADD_LAT + 1);
  localparam int VW = `DATA_PRECISION;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_fifo_cnt;
  logic [ADD_LAT-1:0]      r_infl;
  logic [IW-1:0]           w_infl_cnt;
  logic [BITS_ROW_IDX-1:0] r_row_mem [DEPTH];
  logic [VW-1:0]           r_val_mem [DEPTH];
  logic [BITS_ROW_IDX-1:0] r_last_row;
  logic                    r_have_last;
  logic [15:0]             r_out_count;
  logic                    r_order_err;

  logic [BITS_ROW_IDX-1:0] w_in_row;
  logic [VW-1:0]           w_in_val;
  logic                    w_in_vld, w_active, w_full, w_empty;
  logic                    w_push, w_drop, w_pop, w_ooo, w_start_run, w_credit;

  assign w_in_row    = data_out_add_stg[DATA_WIDTH-1 -: BITS_ROW_IDX];
  assign w_in_val    = data_out_add_stg[DATA_WIDTH-BITS_ROW_IDX-1 -: VW];
  assign w_in_vld    = data_out_add_stg[0];
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_full      = (r_fifo_cnt == CW'(DEPTH));
  assign w_empty     = (r_fifo_cnt == '0);
  assign w_push      = w_active & w_in_vld & ~w_full;
  assign w_drop      = w_active & w_in_vld & w_full;
  assign w_pop       = ~w_empty & out_ready;
  assign w_ooo       = w_push & r_have_last & (w_in_row <= r_last_row);
  assign w_start_run = start & ((r_state == S_IDLE) || (r_state == S_DONE));
  // Pops in the current cycle are deliberately not credited back yet.
  assign w_credit    = (int'(r_fifo_cnt) + int'(w_infl_cnt)) < DEPTH;

  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < ADD_LAT; i++) w_infl_cnt = w_infl_cnt + IW'(r_infl[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (data_ended) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((w_infl_cnt == '0) && w_empty) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    add_en = (r_state == S_RUN) & ~data_ended & w_credit;
    done   = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_infl      <= '0;
      r_out_count <= '0;
      r_order_err <= 1'b0;
      r_have_last <= 1'b0;
      r_last_row  <= '0;
    end else begin
      r_infl <= (r_infl << 1) | ADD_LAT'(add_en);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_start_run) begin
        r_out_count <= '0;
        r_order_err <= 1'b0;
        r_have_last <= 1'b0;
      end else begin
        if (w_pop && (r_out_count != 16'hFFFF)) r_out_count <= r_out_count + 16'd1;
        if (w_ooo || w_drop) r_order_err <= 1'b1;
        if (w_push) begin
          r_have_last <= 1'b1;
          r_last_row  <= w_in_row;
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_row_mem[r_wr_ptr] <= w_in_row;
      r_val_mem[r_wr_ptr] <= w_in_val;
    end
  end

  assign out_valid   = ~w_empty;
  assign out_row_idx = w_empty ? '0 : r_row_mem[r_rd_ptr];
  assign out_value   = w_empty ? '0 : r_val_mem[r_rd_ptr];
  assign out_count   = r_out_count;
  assign order_err   = r_order_err;

endmodule
